// File: rtl/psum_adder_node_pkg.sv
// Shared packet-field offsets, type codes, PE/adder addresses and the PE source decode
// used by the psum adder node.
package psum_adder_node_pkg;

  localparam int SRC_LSB  = 60;
  localparam int DST_LSB  = 56;
  localparam int TYPE_LSB = 54;
  localparam int IDX_LSB  = 17;
  localparam int FLAG_BIT = 16;
  localparam int IDX_W    = 5;

  typedef enum logic [1:0] {
    PKT_IFMAP  = 2'b00,
    PKT_FILTER = 2'b01,
    PKT_PSUM   = 2'b10,
    PKT_RESULT = 2'b11
  } pktType_e;

  localparam logic [3:0] PE0_ADDR    = 4'b0000;
  localparam logic [3:0] PE1_ADDR    = 4'b0001;
  localparam logic [3:0] PE2_ADDR    = 4'b0010;
  localparam logic [3:0] PE3_ADDR    = 4'b0011;
  localparam logic [3:0] PE4_ADDR    = 4'b1001;
  localparam logic [3:0] ADDER_ADDR  = 4'b0100;
  localparam logic [3:0] NEURON_ADDR = 4'b1111;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } srcDec_t;

  function automatic srcDec_t decodeSrc(input logic [3:0] src);
    srcDec_t d;
    d.valid = 1'b1;
    d.idx   = 3'd0;
    case (src)
      PE0_ADDR: d.idx = 3'd0;
      PE1_ADDR: d.idx = 3'd1;
      PE2_ADDR: d.idx = 3'd2;
      PE3_ADDR: d.idx = 3'd3;
      PE4_ADDR: d.idx = 3'd4;
      default:  d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/psum_adder_node_if.sv
// Inbound psum and outbound result packet handshakes of the psum adder node.
interface psum_adder_node_if #(
  parameter int PACKET_WIDTH = 64
);

  logic                    in_valid;
  logic                    in_ready;
  logic [PACKET_WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [PACKET_WIDTH-1:0] out_data;
  logic                    err_drop;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, err_drop
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, err_drop
  );

endinterface

// File: rtl/psum_window_entry.sv
// One accumulation-window entry: running psum total plus the mask of sources that
// have contributed to it.
module psum_window_entry
  import psum_adder_node_pkg::*;
#(
  parameter int PSUM_WIDTH = 13,
  parameter int SUM_WIDTH  = 16,
  parameter int NUM_SRC    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  add,
  input  logic [PSUM_WIDTH-1:0] addVal,
  input  logic [NUM_SRC-1:0]    addMask,
  input  logic                  clear,
  output logic [SUM_WIDTH-1:0]  sum,
  output logic                  complete
);

  logic [NUM_SRC-1:0] mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      mask <= '0;
    end else if (clear) begin
      sum  <= '0;
      mask <= '0;
    end else if (add) begin
      sum  <= sum + SUM_WIDTH'(addVal);
      mask <= mask | addMask;
    end
  end

  assign complete = &mask;

endmodule

// File: rtl/psum_adder_node.sv
// Sums the five row psums of each output position and emits results in output order.
// Build option: PSUM_ADDER_SPIKE_EN sets result bit16 when the sum reaches THRESHOLD.
module psum_adder_node
  import psum_adder_node_pkg::*;
#(
  parameter int                    PACKET_WIDTH    = 64,
  parameter int                    ADDR_WIDTH      = 4,
  parameter int                    PSUM_WIDTH      = 13,
  parameter int                    SUM_WIDTH       = 16,
  parameter int                    NUM_SRC         = 5,
  parameter int                    OUTPUTS_PER_ROW = 21,
  parameter int                    DEPTH           = 4,
  parameter logic [ADDR_WIDTH-1:0] NODE_ADDR       = ADDER_ADDR,
  parameter logic [ADDR_WIDTH-1:0] DEST_ADDR       = NEURON_ADDR,
  parameter logic [15:0]           THRESHOLD       = 16'd64
) (
  input logic               clk,
  input logic               rst_n,
  psum_adder_node_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef PSUM_ADDER_SPIKE_EN
  localparam bit SPIKE_EN = 1'b1;
`else
  localparam bit SPIKE_EN = 1'b0;
`endif

  srcDec_t            dec;
  logic               pktOk;
  logic               readyEn;
  logic               accept;
  logic               dropHit;
  logic               retire;
  logic [CNT_W-1:0]   leadCnt [NUM_SRC];
  logic [CNT_W-1:0]   leadSel;
  logic [NUM_SRC-1:0] incVec;
  logic [NUM_SRC-1:0] srcHot;
  logic [PTR_W-1:0]   headPtr;
  logic [PTR_W-1:0]   slot;
  logic [IDX_W-1:0]   outIdx;
  logic [DEPTH-1:0]   addVec;
  logic [DEPTH-1:0]   clrVec;
  logic [DEPTH-1:0]   entComplete;
  logic [SUM_WIDTH-1:0]    entSum [DEPTH];
  logic [SUM_WIDTH-1:0]    headSum;
  logic                    headComplete;
  logic [PACKET_WIDTH-1:0] resultPkt;
  logic                    outValidQ;
  logic [PACKET_WIDTH-1:0] outDataQ;
  logic                    errDropQ;
  logic                    unusedPayload;

  assign dec   = decodeSrc(bus.in_data[SRC_LSB +: 4]);
  assign pktOk = dec.valid
               && (bus.in_data[TYPE_LSB +: 2] == PKT_PSUM)
               && (bus.in_data[DST_LSB +: ADDR_WIDTH] == NODE_ADDR);
  assign leadSel = leadCnt[dec.idx];
  assign unusedPayload = ^bus.in_data[TYPE_LSB-1:PSUM_WIDTH];

  // Ready depends only on the packet header and window occupancy, never on in_valid.
  assign bus.in_ready = readyEn && (!pktOk || (leadSel < CNT_W'(DEPTH)));
  assign accept       = bus.in_valid && bus.in_ready && pktOk;
  assign dropHit      = bus.in_valid && bus.in_ready && !pktOk;

  assign slot         = headPtr + leadSel[PTR_W-1:0];
  assign srcHot       = NUM_SRC'(1) << dec.idx;
  assign headSum      = entSum[headPtr];
  assign headComplete = entComplete[headPtr];
  assign retire       = headComplete && (!outValidQ || bus.out_ready);

  always_comb begin
    addVec = '0;
    clrVec = '0;
    incVec = '0;
    for (int e = 0; e < DEPTH; e++) begin
      addVec[e] = accept && (slot == PTR_W'(e));
      clrVec[e] = retire && (headPtr == PTR_W'(e));
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      incVec[k] = accept && (dec.idx == 3'(k));
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : gEntry
    psum_window_entry #(
      .PSUM_WIDTH (PSUM_WIDTH),
      .SUM_WIDTH  (SUM_WIDTH),
      .NUM_SRC    (NUM_SRC)
    ) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .add      (addVec[e]),
      .addVal   (bus.in_data[PSUM_WIDTH-1:0]),
      .addMask  (srcHot),
      .clear    (clrVec[e]),
      .sum      (entSum[e]),
      .complete (entComplete[e])
    );
  end

  always_comb begin
    resultPkt                      = '0;
    resultPkt[SRC_LSB +: ADDR_WIDTH] = NODE_ADDR;
    resultPkt[DST_LSB +: ADDR_WIDTH] = DEST_ADDR;
    resultPkt[TYPE_LSB +: 2]       = PKT_RESULT;
    resultPkt[IDX_LSB +: IDX_W]    = outIdx;
    resultPkt[FLAG_BIT]            = SPIKE_EN && (headSum >= SUM_WIDTH'(THRESHOLD));
    resultPkt[0 +: 16]             = 16'(headSum);
  end

  // A simultaneous accept and retire for the same source leaves its lead unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SRC; k++) leadCnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (incVec[k] && !retire)      leadCnt[k] <= leadCnt[k] + CNT_W'(1);
        else if (!incVec[k] && retire) leadCnt[k] <= leadCnt[k] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readyEn   <= 1'b0;
      headPtr   <= '0;
      outIdx    <= '0;
      outValidQ <= 1'b0;
      outDataQ  <= '0;
      errDropQ  <= 1'b0;
    end else begin
      readyEn  <= 1'b1;
      errDropQ <= dropHit;
      if (retire) begin
        headPtr   <= headPtr + PTR_W'(1);
        outIdx    <= (outIdx == IDX_W'(OUTPUTS_PER_ROW - 1)) ? '0 : outIdx + IDX_W'(1);
        outValidQ <= 1'b1;
        outDataQ  <= resultPkt;
      end else if (bus.out_ready) begin
        outValidQ <= 1'b0;
      end
    end
  end

  assign bus.out_valid = outValidQ;
  assign bus.out_data  = outDataQ;
  assign bus.err_drop  = errDropQ;

endmodule

// File: doc/psum_adder_node.md
# psum_adder_node

Clocked receive end of the PE psum packet protocol: it accepts type-10 psum packets emitted by the five convolution PEs and sums the five row psums that belong to the same output position. It emits one result packet per output position, strictly in output order, toward the neuron/membrane stage. A small per-position accumulation window absorbs skew between PEs and applies per-source backpressure when a PE runs too far ahead.

## Interface
- PACKET_WIDTH, 64, packet width
- ADDR_WIDTH, 4, address nibble width
- PSUM_WIDTH, 13, psum payload width (packet bits [12:0])
- SUM_WIDTH, 16, accumulated sum width; must be ≥ PSUM_WIDTH+3
- NUM_SRC, 5, number of contributing PEs
- OUTPUTS_PER_ROW, 21, output positions per row; index wraps after OUTPUTS_PER_ROW-1
- DEPTH, 4, accumulation window entries (power of two)
- NODE_ADDR, 4'b0100, this node's address
- DEST_ADDR, 4'b1111, destination of result packets
- THRESHOLD, 16'd64, spike threshold (used only with the spike macro)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  inbound packet valid
- in_ready  out  1  inbound packet accepted when in_valid && in_ready
- in_data  in  PACKET_WIDTH  {src[63:60], dst[59:56], type[55:54], payload}
- out_valid  out  1  result packet valid
- out_ready  in  1  downstream ready
- out_data  out  PACKET_WIDTH  result packet
- err_drop  out  1  one-cycle pulse on a dropped packet

## Operation
- Source decode: src 0000→0, 0001→1, 0010→2, 0011→3, 1001→4.
- Drop rules: unknown src, type≠2'b10, or dst≠NODE_ADDR → packet accepted (in_ready=1), discarded, err_drop pulses the cycle after acceptance; no state changes.
- Per-source lead counter a_k (0..DEPTH): psums from source k held in non-retired entries.
- in_ready = 1 for a dropped packet, else (a_k < DEPTH) for the decoded source; combinational from in_data and state, never from in_valid.
- On accept from k: slot = (head_ptr + a_k) mod DEPTH; sum[slot] += zero-extended payload[12:0]; mask[slot][k] set; a_k increments.
- An entry is complete when mask == all ones. Only the head entry may retire.
- Retire: head complete and output register empty or draining this cycle → load output register; clear head sum/mask; head_ptr+1 mod DEPTH; out_idx+1, wrapping OUTPUTS_PER_ROW-1→0; every a_k decrements.
- Accept and retire in the same cycle for the same source: a_k unchanged; the slot is computed from pre-retire state.
- Result packet: {NODE_ADDR, DEST_ADDR, 2'b11, zeros, bit16 flag, out_idx[21:17], sum[15:0]}; out_idx is 5 bits.
- Sum cannot overflow: 5×(2^13−1) < 2^16.

## Timing
- Reset values: in_ready 0 while rst_n low, then 1 from the first clock after release; out_valid 0; out_data 0; err_drop 0; all a_k, head_ptr, out_idx, sums and masks 0.
- Latency: the accept that completes the head entry at edge t gives out_valid high after edge t+1, provided the output register is free.
- Output holds stable while out_valid && !out_ready. One retire per cycle maximum, for a throughput of one result per cycle.
- A complete non-head entry waits for the head entry.
- A stalled source unblocks in the cycle after a retire.
- Reset mid-operation: all partial sums are discarded and out_valid deasserts asynchronously.

## Configuration
- PSUM_ADDER_SPIKE_EN defined: bit16 = (sum ≥ THRESHOLD).
- PSUM_ADDER_SPIKE_EN undefined: bit16 = 0 and THRESHOLD is unused. All other behaviour is identical.

## Structure
- Shared package holds:
  - packet field offsets
  - type codes: IFMAP 2'b00, FILTER 2'b01, PSUM 2'b10, RESULT 2'b11
  - PE and adder address constants
  - the source-decode function
- Sub-module psum_window_entry: one entry's sum register and mask, with add, clear and complete ports. The top instantiates DEPTH copies.

## Test plan
- Five in-order psums of 3,5,7,11,13 for index 0 → one packet with sum 39 and out_idx 0, out_valid one cycle after the last accept.
- Source 0 sends 5 psums before any other source → in_ready drops on the 5th; once sources 1–4 complete index 0, the stalled packet is accepted the next cycle.
- 21 full rounds of 8191 from all sources → 21 packets with sum 40955 each, out_idx 0..20, then the 22nd round gives out_idx 0.
- Packets with type 01, dst 0111 and src 0101 → each accepted, err_drop pulses, no output packet.
- out_ready held low across 3 completed indices → the first packet stays stable, no loss, then packets drain in order on consecutive cycles.
- With PSUM_ADDER_SPIKE_EN, sums of 63 and 64 → bit16 = 0 then 1; rst_n pulsed low mid-round → out_valid 0 and the next full round reports only new values at out_idx 0.
